// File: rtl/vdp_sprite_row_fetch_if.sv
// Bundles the sprite row fetcher's hit-list, attribute, VRAM, row and status signals.
// Latency: none, wiring only.
// Backpressure: vram_req/vram_ack and row_valid/row_ready pairs carry the flow control.
interface vdp_sprite_row_fetch_if;
    // line control and hit-list writes from the collision evaluator
    logic        line_start;
    logic        hit_write_en;
    logic [7:0]  hit_sprite_id;
    logic [3:0]  hit_y_intersect;
    logic        hit_width_select;
    logic        eval_finished;
    // sprite attribute lookup
    logic [7:0]  attr_read_id;
    logic [9:0]  attr_tile;
    // VRAM read port
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        vram_ack;
    logic [31:0] vram_data;
    // row stream to the line blitter
    logic        row_valid;
    logic        row_ready;
    logic [31:0] row_data;
    logic [7:0]  row_sprite_id;
    logic        row_half;
    // per-line status
    logic        fetch_done;
    logic        overflow;

    // fetcher side
    modport master (
        input  line_start, hit_write_en, hit_sprite_id, hit_y_intersect, hit_width_select,
        input  eval_finished, attr_tile, vram_ack, vram_data, row_ready,
        output attr_read_id, vram_req, vram_addr, row_valid, row_data, row_sprite_id,
        output row_half, fetch_done, overflow
    );

    // evaluator / attribute RAM / VRAM / blitter side
    modport slave (
        output line_start, hit_write_en, hit_sprite_id, hit_y_intersect, hit_width_select,
        output eval_finished, attr_tile, vram_ack, vram_data, row_ready,
        input  attr_read_id, vram_req, vram_addr, row_valid, row_data, row_sprite_id,
        input  row_half, fetch_done, overflow
    );
endinterface

// File: rtl/vdp_sprite_row_fetch.sv
// Collects per-line sprite hits, then fetches one 4bpp 8-px VRAM row per hit half and streams them out.
// Latency: ATTR_LATENCY+1 cycles of attribute lookup, then VRAM ack + 1 cycle to row_valid.
// Backpressure: vram_addr held until vram_ack; row_valid/row_data held until row_ready; line_start aborts anything.
module vdp_sprite_row_fetch #(
    parameter int MAX_HITS     = 64,
    parameter int ATTR_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    vdp_sprite_row_fetch_if.master bus
);
    localparam int PTR_W = $clog2(MAX_HITS);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(ATTR_LATENCY + 1) + 1;

    typedef struct packed {
        logic [7:0] id;
        logic [3:0] y;
        logic       wide;
    } hit_t;

    typedef enum logic [2:0] {IDLE, COLLECT, ATTR, REQ, EMIT, DONE} state_t;

    state_t           state, state_nxt;
    hit_t             hit_mem [MAX_HITS];
    hit_t             cur_hit;
    logic [CNT_W-1:0] hit_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [LAT_W-1:0] attr_cnt;
    logic [9:0]       tile_q;
    logic             half_q;
    logic             overflow_q;
    logic [31:0]      row_data_q;
    logic [7:0]       row_id_q;
    logic             row_half_q;

    logic hit_store, hit_drop, attr_done, vram_take, row_xfer, last_hit, next_half;

    // The hit list is frozen once collection ends, so the current entry can be read combinationally.
    assign cur_hit   = hit_mem[rd_ptr];
    assign hit_store = (state == COLLECT) && bus.hit_write_en && !bus.eval_finished
                       && (hit_count != CNT_W'(MAX_HITS));
    assign hit_drop  = (state == COLLECT) && bus.hit_write_en && !bus.eval_finished
                       && (hit_count == CNT_W'(MAX_HITS));
    assign attr_done = (state == ATTR) && (attr_cnt == LAT_W'(ATTR_LATENCY));
    assign vram_take = (state == REQ) && bus.vram_ack;
    assign row_xfer  = (state == EMIT) && bus.row_ready;
    assign next_half = cur_hit.wide && !half_q;
    assign last_hit  = ({1'b0, rd_ptr} + CNT_W'(1)) == hit_count;

    // Next-state selection and state-decoded outputs; line_start overrides every state.
    always_comb begin
        state_nxt         = state;
        bus.vram_req      = 1'b0;
        bus.row_valid     = 1'b0;
        bus.fetch_done    = 1'b0;
        bus.attr_read_id  = 8'd0;
        bus.vram_addr     = 14'd0;
        case (state)
            COLLECT: begin
                if (bus.eval_finished)
                    state_nxt = (hit_count == '0) ? DONE : ATTR;
            end
            ATTR: begin
                bus.attr_read_id = cur_hit.id;
                if (attr_done)
                    state_nxt = REQ;
            end
            REQ: begin
                bus.vram_req  = 1'b1;
                // Right half uses the next tile; the 10-bit add wraps at 1024 naturally.
                bus.vram_addr = {tile_q + {9'd0, half_q}, cur_hit.y};
                if (vram_take)
                    state_nxt = EMIT;
            end
            EMIT: begin
                bus.row_valid = 1'b1;
                if (row_xfer) begin
                    if (next_half)
                        state_nxt = REQ;
                    else if (last_hit)
                        state_nxt = DONE;
                    else
                        state_nxt = ATTR;
                end
            end
            DONE: begin
                bus.fetch_done = 1'b1;
            end
            default: state_nxt = state;
        endcase
        if (bus.line_start)
            state_nxt = COLLECT;
    end

    assign bus.row_data      = row_data_q;
    assign bus.row_sprite_id = row_id_q;
    assign bus.row_half      = row_half_q;
    assign bus.overflow      = overflow_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Hit-list storage; plain RAM, contents are only meaningful below hit_count.
    always_ff @(posedge clk) begin
        if (hit_store && !bus.line_start)
            hit_mem[hit_count[PTR_W-1:0]] <= '{id: bus.hit_sprite_id, y: bus.hit_y_intersect,
                                               wide: bus.hit_width_select};
    end

    // Hit counting, overflow flag, read pointer, attribute wait and tile/half tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            overflow_q <= 1'b0;
            rd_ptr     <= '0;
            attr_cnt   <= '0;
            tile_q     <= '0;
            half_q     <= 1'b0;
        end else if (bus.line_start) begin
            hit_count  <= '0;
            overflow_q <= 1'b0;
            rd_ptr     <= '0;
            attr_cnt   <= '0;
            half_q     <= 1'b0;
        end else begin
            if (hit_store)
                hit_count <= hit_count + CNT_W'(1);
            if (hit_drop)
                overflow_q <= 1'b1;
            attr_cnt <= ((state == ATTR) && !attr_done) ? attr_cnt + LAT_W'(1) : '0;
            if (attr_done) begin
                tile_q <= bus.attr_tile;
                half_q <= 1'b0;
            end
            if (row_xfer) begin
                if (next_half)
                    half_q <= 1'b1;
                else if (!last_hit)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Row payload captured on the VRAM ack cycle and held until the blitter takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_data_q <= '0;
            row_id_q   <= '0;
            row_half_q <= 1'b0;
        end else if (vram_take && !bus.line_start) begin
            row_data_q <= bus.vram_data;
            row_id_q   <= cur_hit.id;
            row_half_q <= half_q;
        end
    end
endmodule

// File: doc/vdp_sprite_row_fetch.md
VDP_SPRITE_ROW_FETCH -- requirements
Module: vdp_sprite_row_fetch

Interface
REQ-001 SHALL have parameter MAX_HITS, default 64, meaning the hit entries stored per line (power of 2, 2..256).
REQ-002 SHALL have parameter ATTR_LATENCY, default 1, meaning the cycles from attr_read_id to valid attr_tile.
REQ-003 SHALL have port clk, input, 1, meaning the single clock.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port line_start, input, 1, meaning synchronous restart for a new line (same cycle as evaluator restart).
REQ-006 SHALL have port hit_write_en, input, 1, meaning a hit entry write from the collision evaluator.
REQ-007 SHALL have port hit_sprite_id, input, 8, meaning the sprite id of the hit.
REQ-008 SHALL have port hit_y_intersect, input, 4, meaning the row within the sprite (already flipped).
REQ-009 SHALL have port hit_width_select, input, 1, meaning 1=16px wide, 0=8px.
REQ-010 SHALL have port eval_finished, input, 1, meaning the evaluator is done; a write in a cycle with eval_finished=1 is the terminator.
REQ-011 SHALL have ports attr_read_id (output, 8, sprite id to look up) and attr_tile (input, 10, tile base of that sprite).
REQ-012 SHALL have ports vram_req (output, 1), vram_addr (output, 14), vram_ack (input, 1) and vram_data (input, 32), meaning a VRAM read with data valid on the vram_ack cycle.
REQ-013 SHALL have ports row_valid (output, 1), row_ready (input, 1), row_data (output, 32), row_sprite_id (output, 8) and row_half (output, 1), meaning one 8-px 4bpp row to the line blitter.
REQ-014 SHALL have ports fetch_done (output, 1, all rows for the line emitted) and overflow (output, 1, hits dropped this line).

Function
REQ-015 SHALL store each hit_write_en entry that arrives with eval_finished=0 at address hit_count, store {id,y,width}, and increment hit_count (0..MAX_HITS).
REQ-016 SHALL drop writes when hit_count==MAX_HITS, set overflow=1 (sticky until line_start) and leave hit_count unchanged.
REQ-017 SHALL ignore terminator writes (eval_finished=1) for storage.
REQ-018 SHALL use FSM states IDLE, COLLECT, ATTR, REQ, EMIT, DONE; line_start forces COLLECT from any state and clears hit_count, read pointer, overflow, fetch_done, vram_req and row_valid.
REQ-019 SHALL transition COLLECT->DONE when eval_finished=1 and hit_count==0, and COLLECT->ATTR when eval_finished=1 and hit_count>0.
REQ-020 SHALL, in ATTR, drive attr_read_id=stored id[rd_ptr], wait ATTR_LATENCY cycles, latch attr_tile, set half=0 and go to REQ.
REQ-021 SHALL, in REQ, hold vram_req=1 with vram_addr={(tile+half) mod 1024, y[3:0]} stable until vram_ack; on ack latch vram_data, drop vram_req in the next cycle and go to EMIT.
REQ-022 SHALL, in EMIT, hold row_valid=1 with row_data, row_sprite_id and row_half stable until row_ready; a transfer occurs on the cycle where row_valid&&row_ready.
REQ-023 SHALL, after a transfer: if width=1 and half=0, set half=1 and go to REQ; else if rd_ptr+1==hit_count go to DONE; else increment rd_ptr and go to ATTR.
REQ-024 SHALL, in DONE, assert fetch_done=1 and hold until line_start.
REQ-025 SHALL emit rows in hit-list order, left half before right half.
REQ-026 SHALL ignore vram_ack outside REQ.
REQ-027 SHALL give line_start priority over a simultaneous vram_ack, row_ready or hit_write_en (the line_start cycle's write is discarded).
REQ-028 SHALL ignore eval_finished outside COLLECT.

Reset
REQ-029 SHALL, while reset_n=0, put the FSM in IDLE and drive vram_req=0, vram_addr=0, row_valid=0, row_data=0, row_sprite_id=0, row_half=0, attr_read_id=0, fetch_done=0, overflow=0 and hit_count=0.
REQ-030 SHALL leave IDLE only on line_start.

Verification
REQ-031 SHALL be tested with: line_start, eval_finished with no writes -> fetch_done=1 in 2 cycles, no vram_req.
REQ-032 SHALL be tested with: one hit id=5, y=3, width=0, attr_tile=0x010, immediate ack and ready -> one vram_addr=0x0103, row_sprite_id=5, row_half=0, then fetch_done.
REQ-033 SHALL be tested with: one hit width=1, tile=0x3FF, y=0xF -> addresses 0x3FFF then 0x000F (wrap), row_half 0 then 1.
REQ-034 SHALL be tested with: MAX_HITS+3 writes -> overflow=1, exactly MAX_HITS rows emitted in order.
REQ-035 SHALL be tested with: row_ready held low 10 cycles -> row_valid and row_data stable throughout; vram_ack delayed 5 cycles -> vram_addr stable.
REQ-036 SHALL be tested with: line_start mid-REQ -> vram_req=0 next cycle, stale ack ignored, new line fetched correctly.
